// File: rtl/ysyx_041461_defines.sv
// Shared encodings for the ysyx_041461 memory stage: access controls, trap codes,
// FSM state codes and small decode helpers.
package ysyx_041461_defines;

  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] LB      = 4'd1;
  localparam logic [3:0] LH      = 4'd2;
  localparam logic [3:0] LW      = 4'd3;
  localparam logic [3:0] LD      = 4'd4;
  localparam logic [3:0] LBU     = 4'd5;
  localparam logic [3:0] LHU     = 4'd6;
  localparam logic [3:0] LWU     = 4'd7;
  localparam logic [3:0] SB      = 4'd8;
  localparam logic [3:0] SH      = 4'd9;
  localparam logic [3:0] SW      = 4'd10;
  localparam logic [3:0] SD      = 4'd11;

  localparam logic [3:0] TRAP_NOP         = 4'd0;
  localparam logic [3:0] TRAP_LD_MISALIGN = 4'd4;
  localparam logic [3:0] TRAP_ST_MISALIGN = 4'd6;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  function automatic logic is_load(input logic [3:0] c);
    return (c >= LB) && (c <= LWU);
  endfunction

  function automatic logic is_store(input logic [3:0] c);
    return (c >= SB) && (c <= SD);
  endfunction

endpackage

// File: rtl/ysyx_041461_LSU_ALIGN.sv
// Byte-lane logic for the memory stage: misalignment check, store lane shift/mask
// and load extract with sign/zero extension. Purely combinational.
module ysyx_041461_LSU_ALIGN
  import ysyx_041461_defines::*;
(
  input  logic [3:0]  ctrl,
  input  logic [2:0]  off,
  input  logic [63:0] rs2,
  input  logic [63:0] rdata,
  output logic        misalign,
  output logic [63:0] wdata,
  output logic [7:0]  wmask,
  output logic [63:0] ldata
);

  logic [63:0] sh;
  logic [7:0]  base_mask;

  assign sh = rdata >> {off, 3'b000};

  // NOTE: every always_comb output gets a default before the case so no latch is inferred.
  always_comb begin
    misalign  = 1'b0;
    ldata     = '0;
    base_mask = 8'h00;
    case (ctrl)
      LH, LHU, SH:  misalign = off[0];
      LW, LWU, SW:  misalign = (off[1:0] != 2'b00);
      LD, SD:       misalign = (off != 3'b000);
      default:      misalign = 1'b0;
    endcase
    case (ctrl)
      LB:      ldata = {{56{sh[7]}},  sh[7:0]};
      LH:      ldata = {{48{sh[15]}}, sh[15:0]};
      LW:      ldata = {{32{sh[31]}}, sh[31:0]};
      LD:      ldata = sh;
      LBU:     ldata = {56'd0, sh[7:0]};
      LHU:     ldata = {48'd0, sh[15:0]};
      LWU:     ldata = {32'd0, sh[31:0]};
      default: ldata = '0;
    endcase
    case (ctrl)
      SB:      base_mask = 8'h01;
      SH:      base_mask = 8'h03;
      SW:      base_mask = 8'h0F;
      SD:      base_mask = 8'hFF;
      default: base_mask = 8'h00;
    endcase
  end

  assign wmask = base_mask << off;
  assign wdata = is_store(ctrl) ? (rs2 << {off, 3'b000}) : 64'd0;

endmodule

// File: rtl/ysyx_041461_mem_stage.sv
// Memory-access stage: zero-cycle pass-through for ALU results and traps, and an
// IDLE/REQ/WAIT/DONE sequencer for aligned loads/stores over a valid/ready bus.
module ysyx_041461_mem_stage
  import ysyx_041461_defines::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_valid_in,
  input  logic [3:0]  MEM_trap_in,
  input  logic [63:0] MEM_EXE_out,
  input  logic [63:0] MEM_rs2_data,
  input  logic [3:0]  MEM_ctrl,
  input  logic        MEM_WB_ready,
  output logic        MEM_ready,
  output logic        MEM_valid_out,
  output logic [63:0] MEM_out,
  output logic [3:0]  MEM_trap_out,
  output logic        MEM_req_valid,
  input  logic        MEM_req_ready,
  output logic        MEM_req_wen,
  output logic [63:0] MEM_req_addr,
  output logic [63:0] MEM_req_wdata,
  output logic [7:0]  MEM_req_wmask,
  input  logic        MEM_resp_valid,
  input  logic [63:0] MEM_resp_rdata
);

  logic [1:0]  state, state_nxt;
  logic [63:0] addr_q, rs2_q, rdata_q;
  logic [3:0]  ctrl_q;
  logic        accept;

  logic [3:0]  a_ctrl;
  logic [2:0]  a_off;
  logic        misalign;
  logic [63:0] lane_wdata, lane_ldata;
  logic [7:0]  lane_wmask;

  // In IDLE the lane logic classifies the incoming op; afterwards it serves the latched one.
  assign a_ctrl = (state == S_IDLE) ? MEM_ctrl : ctrl_q;
  assign a_off  = (state == S_IDLE) ? MEM_EXE_out[2:0] : addr_q[2:0];

  ysyx_041461_LSU_ALIGN u_align (
    .ctrl     (a_ctrl),
    .off      (a_off),
    .rs2      (rs2_q),
    .rdata    (rdata_q),
    .misalign (misalign),
    .wdata    (lane_wdata),
    .wmask    (lane_wmask),
    .ldata    (lane_ldata)
  );

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    MEM_ready     = 1'b0;
    MEM_valid_out = 1'b0;
    MEM_out       = '0;
    MEM_trap_out  = TRAP_NOP;
    MEM_req_valid = 1'b0;
    MEM_req_wen   = 1'b0;
    MEM_req_addr  = '0;
    MEM_req_wdata = '0;
    MEM_req_wmask = '0;
    if (rst) begin
      case (state)
        S_IDLE: begin
          if (!MEM_valid_in) begin
            MEM_ready = 1'b1;
          end else if (!(is_load(MEM_ctrl) || is_store(MEM_ctrl)) ||
                       (MEM_trap_in != TRAP_NOP)) begin
            MEM_valid_out = 1'b1;
            MEM_out       = MEM_EXE_out;
            MEM_trap_out  = MEM_trap_in;
            MEM_ready     = MEM_WB_ready;
          end else if (misalign) begin
            MEM_valid_out = 1'b1;
            MEM_out       = MEM_EXE_out;
            MEM_trap_out  = is_store(MEM_ctrl) ? TRAP_ST_MISALIGN : TRAP_LD_MISALIGN;
            MEM_ready     = MEM_WB_ready;
          end else begin
            MEM_ready = 1'b1;
            accept    = 1'b1;
            state_nxt = S_REQ;
          end
        end
        S_REQ: begin
          MEM_req_valid = 1'b1;
          MEM_req_wen   = is_store(ctrl_q);
          MEM_req_addr  = {addr_q[63:3], 3'b000};
          MEM_req_wdata = lane_wdata;
          MEM_req_wmask = lane_wmask;
          if (MEM_req_ready) state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (MEM_resp_valid) state_nxt = S_DONE;
        end
        S_DONE: begin
          MEM_valid_out = 1'b1;
          MEM_out       = is_load(ctrl_q) ? lane_ldata : 64'd0;
          if (MEM_WB_ready) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      rs2_q   <= '0;
      rdata_q <= '0;
      ctrl_q  <= MEM_NOP;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q <= MEM_EXE_out;
        ctrl_q <= MEM_ctrl;
        rs2_q  <= MEM_rs2_data;
      end
      if ((state == S_WAIT) && MEM_resp_valid && is_load(ctrl_q))
        rdata_q <= MEM_resp_rdata;
    end
  end

endmodule

// File: tb/tb_ysyx_041461_mem_stage.sv
// Directed self-checking bench for ysyx_041461_mem_stage with hand-computed vectors.
module tb_ysyx_041461_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_valid_in;
  logic [3:0]  MEM_trap_in;
  logic [63:0] MEM_EXE_out;
  logic [63:0] MEM_rs2_data;
  logic [3:0]  MEM_ctrl;
  logic        MEM_WB_ready;
  logic        MEM_ready;
  logic        MEM_valid_out;
  logic [63:0] MEM_out;
  logic [3:0]  MEM_trap_out;
  logic        MEM_req_valid;
  logic        MEM_req_ready;
  logic        MEM_req_wen;
  logic [63:0] MEM_req_addr;
  logic [63:0] MEM_req_wdata;
  logic [7:0]  MEM_req_wmask;
  logic        MEM_resp_valid;
  logic [63:0] MEM_resp_rdata;

  int errors = 0;
  int checks = 0;
  int hs_count = 0;

  always #5 clk = ~clk;

  ysyx_041461_mem_stage dut (
    .clk            (clk),
    .rst            (rst),
    .MEM_valid_in   (MEM_valid_in),
    .MEM_trap_in    (MEM_trap_in),
    .MEM_EXE_out    (MEM_EXE_out),
    .MEM_rs2_data   (MEM_rs2_data),
    .MEM_ctrl       (MEM_ctrl),
    .MEM_WB_ready   (MEM_WB_ready),
    .MEM_ready      (MEM_ready),
    .MEM_valid_out  (MEM_valid_out),
    .MEM_out        (MEM_out),
    .MEM_trap_out   (MEM_trap_out),
    .MEM_req_valid  (MEM_req_valid),
    .MEM_req_ready  (MEM_req_ready),
    .MEM_req_wen    (MEM_req_wen),
    .MEM_req_addr   (MEM_req_addr),
    .MEM_req_wdata  (MEM_req_wdata),
    .MEM_req_wmask  (MEM_req_wmask),
    .MEM_resp_valid (MEM_resp_valid),
    .MEM_resp_rdata (MEM_resp_rdata)
  );

  always @(posedge clk) if (rst && MEM_req_valid && MEM_req_ready) hs_count <= hs_count + 1;

  task automatic idle_inputs();
    MEM_valid_in = 1'b0; MEM_trap_in = 4'd0; MEM_EXE_out = '0; MEM_rs2_data = '0;
    MEM_ctrl = 4'd0; MEM_WB_ready = 1'b1; MEM_req_ready = 1'b0;
    MEM_resp_valid = 1'b0; MEM_resp_rdata = '0;
  endtask

  // Full aligned transaction: accept, REQ with req_stall stall cycles, a stray response
  // in the handshake cycle, one idle WAIT cycle, response, then DONE with wb_stall stalls.
  task automatic mem_txn(input string tag, input logic [63:0] addr, input logic [3:0] c,
                         input logic [63:0] rs2v, input logic [63:0] rdata,
                         input int req_stall, input int wb_stall,
                         input logic exp_wen, input logic [63:0] exp_addr,
                         input logic [63:0] exp_wdata, input logic [7:0] exp_wmask,
                         input logic [63:0] exp_out);
    int hs0;
    hs0 = hs_count;
    @(negedge clk);
    MEM_valid_in = 1'b1; MEM_ctrl = c; MEM_EXE_out = addr; MEM_rs2_data = rs2v;
    MEM_trap_in = 4'd0; MEM_WB_ready = 1'b1;
    #1;
    checks++; if (MEM_ready !== 1'b1 || MEM_valid_out !== 1'b0 || MEM_req_valid !== 1'b0) begin
      errors++; $display("FAIL %s_accept: ready=%b valid_out=%b req_valid=%b, need 1 0 0", tag, MEM_ready, MEM_valid_out, MEM_req_valid); end
    @(negedge clk);
    MEM_valid_in = 1'b0; MEM_ctrl = 4'd0; MEM_EXE_out = '0; MEM_rs2_data = '0;
    for (int i = 0; i <= req_stall; i++) begin
      MEM_req_ready = (i == req_stall);
      if (i == req_stall) begin MEM_resp_valid = 1'b1; MEM_resp_rdata = ~rdata; end
      #1;
      checks++; if (MEM_req_valid !== 1'b1 || MEM_req_wen !== exp_wen || MEM_req_addr !== exp_addr ||
                    MEM_req_wdata !== exp_wdata || MEM_req_wmask !== exp_wmask || MEM_ready !== 1'b0) begin
        errors++; $display("FAIL %s_req%0d: v=%b wen=%b addr=%h wdata=%h wmask=%h rdy=%b, need 1 %b %h %h %h 0",
                           tag, i, MEM_req_valid, MEM_req_wen, MEM_req_addr, MEM_req_wdata, MEM_req_wmask, MEM_ready,
                           exp_wen, exp_addr, exp_wdata, exp_wmask); end
      @(negedge clk);
    end
    MEM_req_ready = 1'b0; MEM_resp_valid = 1'b0; MEM_resp_rdata = '0;
    #1;
    checks++; if (MEM_req_valid !== 1'b0 || MEM_valid_out !== 1'b0 || MEM_ready !== 1'b0) begin
      errors++; $display("FAIL %s_wait: req_valid=%b valid_out=%b ready=%b, need 0 0 0", tag, MEM_req_valid, MEM_valid_out, MEM_ready); end
    @(negedge clk);
    MEM_resp_valid = 1'b1; MEM_resp_rdata = rdata;
    #1;
    checks++; if (MEM_valid_out !== 1'b0) begin
      errors++; $display("FAIL %s_resp: valid_out=%b, need 0", tag, MEM_valid_out); end
    @(negedge clk);
    MEM_resp_valid = 1'b0; MEM_resp_rdata = '0;
    for (int j = 0; j <= wb_stall; j++) begin
      MEM_WB_ready = (j == wb_stall);
      #1;
      checks++; if (MEM_valid_out !== 1'b1 || MEM_out !== exp_out || MEM_trap_out !== 4'd0 || MEM_ready !== 1'b0) begin
        errors++; $display("FAIL %s_done%0d: valid_out=%b out=%h trap=%0d ready=%b, need 1 %h 0 0",
                           tag, j, MEM_valid_out, MEM_out, MEM_trap_out, MEM_ready, exp_out); end
      @(negedge clk);
    end
    #1;
    checks++; if (MEM_valid_out !== 1'b0 || MEM_req_valid !== 1'b0 || MEM_ready !== 1'b1 || hs_count !== hs0 + 1) begin
      errors++; $display("FAIL %s_end: valid_out=%b req_valid=%b ready=%b handshakes=%0d, need 0 0 1 %0d",
                         tag, MEM_valid_out, MEM_req_valid, MEM_ready, hs_count - hs0, 1); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    MEM_valid_in = 1'b1; MEM_EXE_out = 64'h55;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (MEM_valid_out !== 1'b0 || MEM_ready !== 1'b0 || MEM_out !== 64'd0 || MEM_req_valid !== 1'b0 ||
                  MEM_trap_out !== 4'd0 || MEM_req_addr !== 64'd0) begin
      errors++; $display("FAIL reset: valid_out=%b ready=%b out=%h req_valid=%b, need all 0", MEM_valid_out, MEM_ready, MEM_out, MEM_req_valid); end
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    #1;
    checks++; if (MEM_ready !== 1'b1 || MEM_valid_out !== 1'b0) begin
      errors++; $display("FAIL reset_release: ready=%b valid_out=%b, need 1 0", MEM_ready, MEM_valid_out); end
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    MEM_valid_in = 1'b1; MEM_ctrl = 4'd0; MEM_EXE_out = 64'h1234; MEM_WB_ready = 1'b1;
    #1;
    checks++; if (MEM_valid_out !== 1'b1 || MEM_out !== 64'h1234 || MEM_ready !== 1'b1 || MEM_trap_out !== 4'd0 || MEM_req_valid !== 1'b0) begin
      errors++; $display("FAIL pass_add: valid_out=%b out=%h ready=%b trap=%0d, need 1 1234 1 0", MEM_valid_out, MEM_out, MEM_ready, MEM_trap_out); end
    MEM_WB_ready = 1'b0;
    #1;
    checks++; if (MEM_ready !== 1'b0 || MEM_valid_out !== 1'b1) begin
      errors++; $display("FAIL pass_stall: ready=%b valid_out=%b, need 0 1", MEM_ready, MEM_valid_out); end
    MEM_WB_ready = 1'b1; MEM_ctrl = 4'd4; MEM_trap_in = 4'd2; MEM_EXE_out = 64'h80000010;
    #1;
    checks++; if (MEM_valid_out !== 1'b1 || MEM_trap_out !== 4'd2 || MEM_out !== 64'h80000010 || MEM_req_valid !== 1'b0) begin
      errors++; $display("FAIL pass_trap: valid_out=%b trap=%0d out=%h, need 1 2 80000010", MEM_valid_out, MEM_trap_out, MEM_out); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (MEM_valid_out !== 1'b0 || MEM_ready !== 1'b1 || MEM_req_valid !== 1'b0) begin
      errors++; $display("FAIL pass_invalid: valid_out=%b ready=%b req_valid=%b, need 0 1 0", MEM_valid_out, MEM_ready, MEM_req_valid); end
  endtask

  task automatic test_misalign();
    @(negedge clk);
    MEM_valid_in = 1'b1; MEM_ctrl = 4'd3; MEM_EXE_out = 64'h80000002; MEM_WB_ready = 1'b1;
    #1;
    checks++; if (MEM_req_valid !== 1'b0 || MEM_valid_out !== 1'b1 || MEM_trap_out !== 4'd4 || MEM_out !== 64'h80000002 || MEM_ready !== 1'b1) begin
      errors++; $display("FAIL mis_lw: req_valid=%b valid_out=%b trap=%0d out=%h ready=%b, need 0 1 4 80000002 1",
                         MEM_req_valid, MEM_valid_out, MEM_trap_out, MEM_out, MEM_ready); end
    MEM_WB_ready = 1'b0;
    #1;
    checks++; if (MEM_ready !== 1'b0) begin
      errors++; $display("FAIL mis_stall: ready=%b, need 0", MEM_ready); end
    @(negedge clk);
    MEM_WB_ready = 1'b1; MEM_ctrl = 4'd11; MEM_EXE_out = 64'h80000004;
    #1;
    checks++; if (MEM_req_valid !== 1'b0 || MEM_trap_out !== 4'd6 || MEM_valid_out !== 1'b1) begin
      errors++; $display("FAIL mis_sd: req_valid=%b trap=%0d valid_out=%b, need 0 6 1", MEM_req_valid, MEM_trap_out, MEM_valid_out); end
    MEM_ctrl = 4'd9; MEM_EXE_out = 64'h80000003;
    #1;
    checks++; if (MEM_trap_out !== 4'd6 || MEM_out !== 64'h80000003) begin
      errors++; $display("FAIL mis_sh: trap=%0d out=%h, need 6 80000003", MEM_trap_out, MEM_out); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (MEM_req_valid !== 1'b0 || MEM_ready !== 1'b1) begin
      errors++; $display("FAIL mis_after: req_valid=%b ready=%b, need 0 1", MEM_req_valid, MEM_ready); end
  endtask

  task automatic test_lb();
    mem_txn("lb", 64'h80000003, 4'd1, 64'd0, 64'h00000000_80FF0000, 0, 0,
            1'b0, 64'h80000000, 64'd0, 8'h00, 64'hFFFFFFFF_FFFFFF80);
    mem_txn("lh", 64'h80000002, 4'd2, 64'd0, 64'h00000000_80010000, 0, 0,
            1'b0, 64'h80000000, 64'd0, 8'h00, 64'hFFFFFFFF_FFFF8001);
  endtask

  task automatic test_sh();
    mem_txn("sh", 64'h80000006, 4'd9, 64'h000000000000ABCD, 64'd0, 0, 0,
            1'b1, 64'h80000000, 64'hABCD0000_00000000, 8'hC0, 64'd0);
    mem_txn("sw", 64'h80000004, 4'd10, 64'h11223344_55667788, 64'd0, 1, 0,
            1'b1, 64'h80000000, 64'h55667788_00000000, 8'hF0, 64'd0);
  endtask

  task automatic test_back_pressure();
    mem_txn("bp_ld", 64'h80000010, 4'd4, 64'd0, 64'h01234567_89ABCDEF, 5, 3,
            1'b0, 64'h80000010, 64'd0, 8'h00, 64'h01234567_89ABCDEF);
  endtask

  task automatic test_reset_in_wait();
    int hs0;
    hs0 = hs_count;
    @(negedge clk);
    MEM_valid_in = 1'b1; MEM_ctrl = 4'd1; MEM_EXE_out = 64'h80000001;
    @(negedge clk);
    idle_inputs();
    MEM_req_ready = 1'b1;
    @(negedge clk);
    MEM_req_ready = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (MEM_valid_out !== 1'b0 || MEM_ready !== 1'b0 || MEM_req_valid !== 1'b0 || MEM_out !== 64'd0 || hs_count !== hs0 + 1) begin
      errors++; $display("FAIL rst_wait: valid_out=%b ready=%b req_valid=%b out=%h hs=%0d, need 0 0 0 0 1",
                         MEM_valid_out, MEM_ready, MEM_req_valid, MEM_out, hs_count - hs0); end
    @(negedge clk);
    rst = 1'b1;
    MEM_resp_valid = 1'b1; MEM_resp_rdata = 64'hDEADBEEF_DEADBEEF;
    #1;
    checks++; if (MEM_valid_out !== 1'b0 || MEM_ready !== 1'b1 || MEM_req_valid !== 1'b0) begin
      errors++; $display("FAIL rst_stray: valid_out=%b ready=%b req_valid=%b, need 0 1 0", MEM_valid_out, MEM_ready, MEM_req_valid); end
    @(negedge clk);
    MEM_resp_valid = 1'b0; MEM_resp_rdata = '0;
    #1;
    checks++; if (MEM_valid_out !== 1'b0 || MEM_ready !== 1'b1) begin
      errors++; $display("FAIL rst_ignored: valid_out=%b ready=%b, need 0 1", MEM_valid_out, MEM_ready); end
    mem_txn("lwu", 64'h80000004, 4'd7, 64'd0, 64'hFFFFFFFF_00000000, 0, 0,
            1'b0, 64'h80000000, 64'd0, 8'h00, 64'h00000000_FFFFFFFF);
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_misalign();
    test_lb();
    test_sh();
    test_back_pressure();
    test_reset_in_wait();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
